// File: rtl/mem_store_if.sv
// Store request and byte-wide RAM write bus between the load/store path and the RAM/IO arbiter.
// The slave side is the store controller; the master side is everything around it.
interface mem_store_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  store_valid;
  logic [ADDR_WIDTH-1:0] store_addr;
  logic [31:0]           store_data;
  logic [1:0]            store_size;
  logic                  store_ready;
  logic                  store_done;
  logic                  io_buffer_full;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  modport master (
    output store_valid, store_addr, store_data, store_size, io_buffer_full,
    input  store_ready, store_done, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  store_valid, store_addr, store_data, store_size, io_buffer_full,
    output store_ready, store_done, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_store_ctrl.sv
// Serialises one byte/half/word store onto the 8-bit RAM bus, LSB first, one byte per cycle.
// state | meaning
// IDLE  | no store in flight; store_ready may be high
// BUSY  | store latched; emitting byte cnt (held off by a full I/O buffer)
module mem_store_ctrl #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] IO_BASE    = 32'h00030000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  mem_store_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  done_q, done_d;

  logic                  store_ready;
  logic                  accept;
  logic [2:0]            size_n;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [31:0]           src_data;
  logic [2:0]            src_n;
  logic [1:0]            k;
  logic [ADDR_WIDTH-1:0] byte_addr;
  logic                  hold;

  assign store_ready = rdy & ~rst & (state_q == IDLE);
  assign accept      = store_ready & bus.store_valid;

  always_comb begin
    case (bus.store_size)
      2'd0:    size_n = 3'd1;
      2'd1:    size_n = 3'd2;
      default: size_n = 3'd4;
    endcase
  end

  // On the accept edge byte 0 is emitted straight from the request inputs.
  assign src_addr  = accept ? bus.store_addr : addr_q;
  assign src_data  = accept ? bus.store_data : data_q;
  assign src_n     = accept ? size_n : nbytes_q;
  assign k         = accept ? 2'd0 : cnt_q[1:0];
  assign byte_addr = src_addr + ADDR_WIDTH'(k);
  assign hold      = bus.io_buffer_full & (byte_addr >= ADDR_WIDTH'(IO_BASE));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    nbytes_d   = nbytes_q;
    cnt_d      = cnt_q;
    mem_wr_d   = mem_wr_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    done_d     = done_q;

    if (rdy) begin
      if (accept) begin
        addr_d   = bus.store_addr;
        data_d   = bus.store_data;
        nbytes_d = size_n;
        cnt_d    = 3'd0;
        state_d  = BUSY;
      end

      if (accept || state_q == BUSY) begin
        if (hold) begin
          mem_wr_d   = 1'b0;
          mem_a_d    = '0;
          mem_dout_d = 8'h00;
          done_d     = 1'b0;
        end else begin
          mem_wr_d   = 1'b1;
          mem_a_d    = byte_addr;
          mem_dout_d = src_data[{k, 3'b000} +: 8];
          cnt_d      = {1'b0, k} + 3'd1;
          if ({1'b0, k} + 3'd1 == src_n) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            done_d  = 1'b0;
          end
        end
      end else begin
        mem_wr_d   = 1'b0;
        mem_a_d    = '0;
        mem_dout_d = 8'h00;
        done_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      nbytes_q   <= 3'd0;
      cnt_q      <= 3'd0;
      mem_wr_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'h00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      nbytes_q   <= nbytes_d;
      cnt_q      <= cnt_d;
      mem_wr_q   <= mem_wr_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      done_q     <= done_d;
    end
  end

  assign bus.store_ready = store_ready;
  assign bus.store_done  = done_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_a       = mem_a_q;
  assign bus.mem_dout    = mem_dout_q;

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Directed and random stimulus for mem_store_ctrl, checked cycle by cycle against a
// transaction-level model of the pending store.
module tb_mem_store_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;

  always #5 clk = ~clk;

  mem_store_if #(.ADDR_WIDTH(32)) bus();

  mem_store_ctrl #(.ADDR_WIDTH(32), .IO_BASE(32'h00030000)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: one pending store with the index of the next byte to go out.
  bit          m_busy = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_n = 0;
  int          m_k = 0;
  logic        e_wr = 1'b0;
  logic [31:0] e_a = '0;
  logic [7:0]  e_dout = '0;
  logic        e_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] a;
    if (rst) begin
      m_busy = 1'b0; m_k = 0; m_n = 0;
      e_wr = 1'b0; e_a = '0; e_dout = '0; e_done = 1'b0;
    end else if (rdy) begin
      if (!m_busy && bus.store_valid) begin
        m_busy = 1'b1;
        m_addr = bus.store_addr;
        m_data = bus.store_data;
        m_n    = (bus.store_size == 2'd0) ? 1 : (bus.store_size == 2'd1) ? 2 : 4;
        m_k    = 0;
      end
      if (m_busy) begin
        a = m_addr + 32'(m_k);
        if (bus.io_buffer_full && a >= 32'h00030000) begin
          e_wr = 1'b0; e_a = '0; e_dout = '0; e_done = 1'b0;
        end else begin
          e_wr   = 1'b1;
          e_a    = a;
          e_dout = 8'((m_data >> (8 * m_k)) & 32'hFF);
          m_k++;
          e_done = (m_k == m_n);
          if (e_done) m_busy = 1'b0;
        end
      end else begin
        e_wr = 1'b0; e_a = '0; e_dout = '0; e_done = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, check store_ready, clock, check registered outputs.
  task automatic cyc(input logic r, input logic y, input logic v, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] s, input logic f);
    rst = r;
    rdy = y;
    bus.store_valid    = v;
    bus.store_addr     = a;
    bus.store_data     = d;
    bus.store_size     = s;
    bus.io_buffer_full = f;
    #1;
    chk("store_ready", 32'(bus.store_ready), 32'(y && !r && !m_busy));
    model_edge();
    @(posedge clk);
    #1;
    chk("mem_wr", 32'(bus.mem_wr), 32'(e_wr));
    chk("mem_a", bus.mem_a, e_a);
    chk("mem_dout", 32'(bus.mem_dout), 32'(e_dout));
    chk("store_done", 32'(bus.store_done), 32'(e_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0, 2'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] ra;
    bus.store_valid = 1'b0;
    bus.store_addr = '0;
    bus.store_data = '0;
    bus.store_size = '0;
    bus.io_buffer_full = 1'b0;
    @(posedge clk);
    #1;

    cyc(1'b1, 1'b1, 1'b1, 32'h10, 32'h1, 2'd2, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 2'd0, 1'b0);
    idle(1);

    // Word store with fixed expected bytes.
    w = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) cyc(1'b0, 1'b1, 1'b1, 32'h100, w, 2'd2, 1'b0);
      else        cyc(1'b0, 1'b1, 1'b0, '0, '0, 2'd0, 1'b0);
      chk("t1_wr", 32'(bus.mem_wr), 32'd1);
      chk("t1_a", bus.mem_a, 32'h100 + 32'(i));
      chk("t1_dout", 32'(bus.mem_dout), (w >> (8 * i)) & 32'hFF);
      chk("t1_done", 32'(bus.store_done), 32'(i == 3));
      if (i == 3) chk("t1_ready", 32'(bus.store_ready), 32'd1);
    end
    idle(1);

    // Byte then half, back to back.
    cyc(1'b0, 1'b1, 1'b1, 32'h20, 32'h55, 2'd0, 1'b0);
    chk("t2_done0", 32'(bus.store_done), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 32'h41, 32'h1234, 2'd1, 1'b0);
    chk("t2_a1", bus.mem_a, 32'h41);
    cyc(1'b0, 1'b1, 1'b0, '0, '0, 2'd0, 1'b0);
    chk("t2_d2", 32'(bus.mem_dout), 32'h12);
    idle(1);

    // I/O hold for three cycles.
    cyc(1'b0, 1'b1, 1'b1, 32'h30000, 32'hA1B2C3D4, 2'd2, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, '0, '0, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, '0, '0, 2'd0, 1'b1);
    idle(4);
    chk("t3_last_a", bus.mem_a, 32'h30003);
    idle(1);

    // rdy stall after byte 1.
    cyc(1'b0, 1'b1, 1'b1, 32'h200, 32'h11223344, 2'd2, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0, '0, 2'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 2'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 2'd0, 1'b0);
    chk("t4_frozen_a", bus.mem_a, 32'h201);
    idle(3);

    // Reset mid-store.
    cyc(1'b0, 1'b1, 1'b1, 32'h300, 32'h99887766, 2'd2, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0, '0, 2'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 2'd0, 1'b0);
    idle(3);

    // Address wrap, size 2 and reserved size 3.
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h0A0B0C0D, 2'd2, 1'b0);
    idle(3);
    chk("t6_wrap_a", bus.mem_a, 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h0A0B0C0D, 2'd3, 1'b0);
    idle(3);
    chk("t6_size3_a", bus.mem_a, 32'h1);
    chk("t6_size3_done", 32'(bus.store_done), 32'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom_range(0, 32'hFFFF);
        1:       ra = 32'h0002FFFE + $urandom_range(0, 3);
        2:       ra = 32'hFFFFFFFC + $urandom_range(0, 3);
        default: ra = $urandom;
      endcase
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
          ra, $urandom, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_store_ctrl.md
Name: mem_store_ctrl

Overview:
- Write-side companion to the byte-serial RAM read controller. It takes one store request (byte, half or word) from the load/store path and serialises it onto the 8-bit RAM bus as consecutive byte writes, least-significant byte first.
- It pauses on `rdy` low and on a full I/O buffer.
- It signals completion with a one-cycle `store_done` pulse.
- It sits between the LSB and the RAM/IO bus arbiter, alongside the instruction-fetch read path.

Parameters:
- ADDR_WIDTH, 32, width of byte address bus
- IO_BASE, 32'h00030000, addresses >= IO_BASE are memory-mapped I/O and subject to io_buffer_full

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes the block
- store_valid  in  1  store request present
- store_addr  in  ADDR_WIDTH  byte address of the lowest byte
- store_data  in  32  store data; byte i = store_data[8i+7:8i]
- store_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- store_ready  out  1  combinational; high when the block can accept a request this cycle
- store_done  out  1  registered one-cycle pulse, coincident with the last byte on the bus
- io_buffer_full  in  1  I/O sink cannot take a byte
- mem_dout  out  8  registered byte to RAM
- mem_a  out  ADDR_WIDTH  registered RAM byte address
- mem_wr  out  1  registered; 1=write this cycle, 0=idle/read

Behaviour:
- Reset: on a clk edge with rst=1, the following are all cleared:
  - state -> IDLE, cnt=0, nbytes=0
  - mem_wr=0, mem_a=0, mem_dout=0, store_done=0
  - store_ready=0 while rst is high
  - an in-flight store is dropped with no done pulse
- rdy=0, rst=0:
  - all registers hold, including the mem_* outputs (a repeated same-byte write is idempotent)
  - store_ready=0 and store_done holds
  - no accept and no advance
- Latched state: addr, data, nbytes (1/2/4 from store_size), cnt (bytes emitted, 0..4), state IDLE/BUSY.
- store_ready = rdy & !rst & state==IDLE.
- Accept: at an edge with store_ready & store_valid:
  - latch addr, data, nbytes; cnt=0; state -> BUSY
  - the same edge also performs an emit attempt for byte 0
  - requests with store_valid=0 are ignored
- Hold condition: hold(k) = io_buffer_full & ((addr+k) >= IO_BASE), evaluated on the current-cycle io_buffer_full.
- Emit attempt for byte k (at an edge, rdy=1):
  - If !hold(k): mem_wr<=1, mem_a<=addr+k (mod 2^ADDR_WIDTH, so 0xFFFFFFFF+1=0), mem_dout<=data[8k+7:8k], cnt<=k+1.
  - If hold(k): mem_wr<=0, mem_a<=0, mem_dout<=0, cnt unchanged.
- BUSY: at every edge with rdy=1, perform an emit attempt for byte cnt.
- Completion:
  - when the emitted byte is the last one (k+1==nbytes): store_done<=1, state<=IDLE
  - otherwise store_done<=0
- Idle edge with no accept: mem_wr, mem_a, mem_dout and store_done all <=0.
- Latency and throughput:
  - byte k is on the bus in cycle k+1 after the accept edge when unstalled
  - a word store occupies the bus for 4 cycles
  - store_ready returns in the same cycle store_done is high, so back-to-back stores give 1 byte/cycle with no bubble
- Alignment: no alignment check; misaligned half/word stores write addr..addr+n-1 as given.
- Bus ordering: the block never drives mem_wr=1 outside BUSY or the accept edge.

Test Plan:
1. Word store: addr=0x100, data=0xDEADBEEF, size=2, rdy=1 -> four consecutive cycles with mem_wr=1 at (0x100,EF), (0x101,BE), (0x102,AD), (0x103,DE); store_done high only in the 4th; store_ready high that cycle.
2. Byte then half back-to-back: (0x20, 0x55, size 0) then (0x41, 0x1234, size 1) -> bus shows (0x20,55) [done], (0x41,34), (0x42,12) [done]; no idle cycle between the two stores.
3. I/O hold: word to 0x30000 with io_buffer_full=1 for the first 3 cycles, then 0 -> mem_wr=0 for 3 cycles, then 4 writes 0x30000..0x30003; store_done on the last write only.
4. rdy stall: rdy=0 for 2 cycles after byte 1 of a word store -> mem_* frozen at (addr+1, byte1), no done; completion delayed exactly 2 cycles.
5. Reset mid-store: rst=1 at the edge after byte 1 of a word store -> next cycle mem_wr=0, mem_a=0, store_done=0; store_ready=1 once rst drops, with no residual bytes emitted.
6. Wrap: word to 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; size=3 behaves identically to size=2.
